alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that borrows the shared 16-bit ALU to run unsigned multiply (low half) and unsigned restoring divide.
- Issues one ALU add or subtract per cycle.
- While running, asserts alu_sel so the top-level ALUC mux selects the sequencer's operands and control code in place of the decoder and ALU-control path.
- Sits beside the ALU control logic in the execute stage; the core stalls on busy.

---
 rtl/alu_muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle sequencer for unsigned multiply (low half) and
// unsigned restoring divide. It borrows the shared W-bit ALU for one add or
// subtract per cycle. While it owns the ALU (RUN), alu_sel steers the ALUC mux
// to alu_a/alu_b/alu_ctrl.
//
// Handshake: start/op/a/b are sampled only in IDLE. busy is high in RUN and
// DONE. done is a one-cycle pulse in the cycle after DONE, and it marks
// result/remainder/div_zero as valid. Those three outputs hold until the next
// completion or reset. A start seen while busy is dropped.
//
// Optional feature: define MULDIV_EARLY_EXIT_EN to let MUL finish as soon as
// the remaining multiplier bits are all zero (b==0 skips RUN entirely).
module alu_muldiv_seq #(
    parameter int         W       = 16,
    parameter logic [3:0] ALU_ADD = 4'd0,
    parameter logic [3:0] ALU_SUB = 4'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] remainder,
    output logic         div_zero,
    output logic         alu_sel,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [W-1:0] alu_result
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic           r_op;        // 0 = MUL, 1 = DIVU
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_mplier;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_div;
    logic           r_done;
    logic [W-1:0]   r_result;
    logic [W-1:0]   r_remainder;
    logic           r_div_zero;

    logic [W-1:0]   w_div_r;
    logic           w_qbit;
    logic [W-1:0]   w_rem_nxt;
    logic [W-1:0]   w_q_nxt;
    logic [W-1:0]   w_acc_nxt;
    logic [W-1:0]   w_mplier_nxt;
    logic           w_last;

    // Next-iteration values for both algorithms; the ALU result feeds back in the same cycle.
    always_comb begin
        // Shift the next dividend bit into the partial remainder. A set rem MSB means
        // the true remainder is at least 2^W > divisor, so the W-bit wrapped
        // difference is still the right answer.
        w_div_r      = {r_rem[W-2:0], r_q[W-1]};
        w_qbit       = r_rem[W-1] | (w_div_r >= r_div);
        w_rem_nxt    = w_qbit ? alu_result : w_div_r;
        w_q_nxt      = {r_q[W-2:0], w_qbit};
        w_acc_nxt    = r_mplier[0] ? alu_result : r_acc;
        w_mplier_nxt = r_mplier >> 1;
        w_last       = (r_count == CW'(W - 1));
`ifdef MULDIV_EARLY_EXIT_EN
        if (!r_op && (w_mplier_nxt == '0)) begin
            w_last = 1'b1;
        end
`endif
    end

    // ALU operand/control drive: active only in RUN, zero otherwise.
    always_comb begin
        alu_sel  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 4'd0;
        if (r_state == RUN) begin
            alu_sel = 1'b1;
            if (r_op) begin
                alu_a    = w_div_r;
                alu_b    = r_div;
                alu_ctrl = ALU_SUB;
            end else begin
                alu_a    = r_acc;
                alu_b    = r_mcand;
                alu_ctrl = ALU_ADD;
            end
        end
    end

    // Sequencer FSM, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_op        <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            // The done pulse trails the single DONE cycle by one clock.
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_rem    <= '0;
                        r_q      <= a;
                        r_div    <= b;
                        if (op && (b == '0)) begin
                            r_state     <= DONE;
                            r_result    <= '1;
                            r_remainder <= a;
                            r_div_zero  <= 1'b1;
                        end
`ifdef MULDIV_EARLY_EXIT_EN
                        else if (!op && (b == '0)) begin
                            r_state     <= DONE;
                            r_result    <= '0;
                            r_remainder <= '0;
                            r_div_zero  <= 1'b0;
                        end
`endif
                        else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_count <= r_count + CW'(1);
                    if (r_op) begin
                        r_rem <= w_rem_nxt;
                        r_q   <= w_q_nxt;
                    end else begin
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= w_mplier_nxt;
                    end
                    if (w_last) begin
                        r_state     <= DONE;
                        r_result    <= r_op ? w_q_nxt : w_acc_nxt;
                        r_remainder <= r_op ? w_rem_nxt : '0;
                        r_div_zero  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign done      = r_done;
    assign result    = r_result;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU on the borrowed port.
module tb_alu_muldiv_seq;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
`ifdef MULDIV_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        div_zero;
    logic        alu_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_result;

    int n_total;
    int n_bad;

    alu_muldiv_seq #(.W(16), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .remainder  (remainder),
        .div_zero   (div_zero),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    // Shared ALU stand-in: combinational add/subtract.
    always_comb begin
        alu_result = (alu_ctrl == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse.
    task automatic run_op(input string tag, input logic o, input logic [15:0] ia,
                          input logic [15:0] ib, input int exp_lat, input int exp_sel,
                          input logic [15:0] exp_res, input logic [15:0] exp_rem,
                          input logic exp_dz, input int inject_at);
        int n;
        int sel_cnt;
        int ctrl_bad;
        int idle_bad;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a     = 16'($urandom);
        b     = 16'($urandom_range(0, 3));
        n = 0; sel_cnt = 0; ctrl_bad = 0; idle_bad = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (alu_sel) begin
                    sel_cnt++;
                    if (alu_ctrl !== (o ? ALU_SUB : ALU_ADD)) ctrl_bad++;
                end else if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_ctrl !== 4'h0) begin
                    idle_bad++;
                end
                if (n == inject_at) start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
            end
        end
        check({tag, ".lat"},    32'(n), 32'(exp_lat));
        check({tag, ".sel"},    32'(sel_cnt), 32'(exp_sel));
        check({tag, ".ctrl"},   32'(ctrl_bad), 32'd0);
        check({tag, ".idle"},   32'(idle_bad), 32'd0);
        check({tag, ".res"},    32'(result), 32'(exp_res));
        check({tag, ".rem"},    32'(remainder), 32'(exp_rem));
        check({tag, ".dz"},     32'(div_zero), 32'(exp_dz));
        @(posedge clk);
        #1;
        check({tag, ".pulse"},  32'({done, busy}), 32'd0);
        check({tag, ".hold"},   32'(result), 32'(exp_res));
    endtask

    initial begin
        int k;
        int done_seen;
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        a       = 16'h0;
        b       = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ctl", 32'({busy, done, div_zero, alu_sel, alu_ctrl}), 32'd0);
        check("reset.res", {result, remainder}, 32'd0);
        check("reset.alu", {alu_a, alu_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply
        run_op("mul_300x7", 1'b0, 16'd300, 16'd7, EE ? 4 : 17, EE ? 3 : 16,
               16'h0834, 16'h0, 1'b0, -1);
        run_op("mul_ffff2", 1'b0, 16'hFFFF, 16'hFFFF, 17, 16, 16'h0001, 16'h0, 1'b0, -1);
        run_op("mul_5x3",   1'b0, 16'd5, 16'd3, EE ? 3 : 17, EE ? 2 : 16,
               16'd15, 16'h0, 1'b0, -1);
        run_op("mul_9x0",   1'b0, 16'd9, 16'd0, EE ? 1 : 17, EE ? 0 : 16,
               16'd0, 16'h0, 1'b0, -1);

        // Divide
        run_op("div_ffff_1", 1'b1, 16'hFFFF, 16'd1, 17, 16, 16'hFFFF, 16'h0, 1'b0, -1);
        run_op("div_1000_7", 1'b1, 16'd1000, 16'd7, 17, 16, 16'd142, 16'd6, 1'b0, -1);
        run_op("div_8001",   1'b1, 16'h8001, 16'h8000, 17, 16, 16'd1, 16'd1, 1'b0, -1);
        run_op("div_zero",   1'b1, 16'h1234, 16'h0, 1, 0, 16'hFFFF, 16'h1234, 1'b1, -1);
        // Divide-by-zero flag must clear on the next normal completion.
        run_op("div_100_10", 1'b1, 16'd100, 16'd10, 17, 16, 16'd10, 16'd0, 1'b0, -1);

        // A start pulse while busy is ignored.
        run_op("mul_inject", 1'b0, 16'd300, 16'd7, EE ? 4 : 17, EE ? 3 : 16,
               16'h0834, 16'h0, 1'b0, 1);
        run_op("div_inject", 1'b1, 16'd1000, 16'd7, 17, 16, 16'd142, 16'd6, 1'b0, 4);

        // Reset in RUN cycle 5 aborts without a done pulse.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 16'd1234;
        b     = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
        end
        check("mid.busy", 32'({busy, alu_sel}), 32'h3);
        rst_n = 1'b0;
        #1;
        check("abort.ctl", 32'({busy, done, div_zero, alu_sel, alu_ctrl}), 32'd0);
        check("abort.res", {result, remainder}, 32'd0);
        check("abort.alu", {alu_a, alu_b}, 32'd0);
        done_seen = 0;
        for (k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort.nodone", 32'(done_seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 1'b1, 16'd1000, 16'd7, 17, 16, 16'd142, 16'd6, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
